// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the EX/MEM M field, drives a handshaked data-memory port,
// aligns load data, resolves redirects and stalls the pipeline. Optional: MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid,
  input  logic [9:0]    m_ctl,
  input  logic          zero,
  input  logic [31:0]   aluout,
  input  logic [31:0]   rd2,
  input  logic [31:0]   rd1,
  input  logic [31:0]   jaddr,
  input  logic [31:0]   addres,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic [31:0]   ld_data,
  output logic          stall,
  output logic          memwb_w,
  output logic          pc_sel,
  output logic [31:0]   pc_target,
  output logic          align_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [1:0]      lo_q;
  logic [1:0]      size_q;
  logic            sext_q;
  logic            rd_q;
  logic [31:0]     ld_q;

  logic            eval;
  logic            is_mem;
  logic            misal;
  logic            start;
  logic            br_taken;
  logic            timeout;
  logic            unused_ok;

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b10:   be_of = 4'b0001 << lo;
      2'b01:   be_of = lo[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b10:   wdata_of = {4{d[7:0]}};
      2'b01:   wdata_of = {2{d[15:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] sz, input logic [1:0] lo,
                                             input logic sx, input logic [31:0] d);
    logic [31:0] sh;
    logic [15:0] hw;
    sh = d >> {lo, 3'b000};
    hw = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b10:   load_align = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   load_align = {{16{sx & hw[15]}}, hw};
      default: load_align = d;
    endcase
  endfunction

  // Decode of the instruction currently held in EX/MEM
  always_comb begin
    eval     = (state == IDLE) && valid;
    is_mem   = m_ctl[0] | m_ctl[1];
    misal    = (m_ctl[7:6] == 2'b11) ||
               ((m_ctl[7:6] == 2'b01) && aluout[0]) ||
               ((m_ctl[7:6] == 2'b00) && (aluout[1:0] != 2'b00));
    start    = eval && is_mem && !misal;
    br_taken = (m_ctl[2] & zero) | (m_ctl[3] & ~zero);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (start)
      cnt <= '0;
    else if (state == ACCESS)
      cnt <= cnt + 1'b1;
  end

  // The last ACCESS cycle without ack aborts the access
  assign timeout = (state == ACCESS) && !dm_ack && (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign unused_ok = ^{m_ctl[9], TIMEOUT[0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      ld_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCESS;
            addr_q  <= {aluout[AW-1:2], 2'b00};
            we_q    <= m_ctl[1];
            be_q    <= be_of(m_ctl[7:6], aluout[1:0]);
            wdata_q <= wdata_of(m_ctl[7:6], rd2);
            lo_q    <= aluout[1:0];
            size_q  <= m_ctl[7:6];
            sext_q  <= m_ctl[8];
            rd_q    <= m_ctl[0] & ~m_ctl[1];
            ld_q    <= '0;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            if (rd_q)
              ld_q <= load_align(size_q, lo_q, sext_q, dm_rdata);
            state <= DONE;
          end else if (timeout) begin
            ld_q  <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port and pipeline-control outputs
  always_comb begin
    dm_req    = (state == ACCESS);
    dm_we     = dm_req & we_q;
    dm_addr   = addr_q;
    dm_be     = be_q;
    dm_wdata  = wdata_q;
    ld_data   = (state == DONE) ? ld_q : 32'h0;
    stall     = start || (state == ACCESS);
    memwb_w   = (eval && (!is_mem || misal)) || (state == DONE);
    align_err = (eval && is_mem && misal) || timeout;
    pc_sel    = eval && (m_ctl[5] || m_ctl[4] || br_taken);
    pc_target = 32'h0;
    if (eval) begin
      if (m_ctl[5])      pc_target = rd1;
      else if (m_ctl[4]) pc_target = jaddr;
      else if (br_taken) pc_target = addres;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of single-cycle IDLE vectors plus
// hand-written memory-access, reset and (with MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [9:0]  m_ctl;
  logic        zero;
  logic [31:0] aluout, rd2, rd1, jaddr, addres;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        stall, memwb_w, pc_sel, align_err;
  logic [31:0] pc_target;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .m_ctl(m_ctl), .zero(zero),
    .aluout(aluout), .rd2(rd2), .rd1(rd1), .jaddr(jaddr), .addres(addres),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .ld_data(ld_data),
    .stall(stall), .memwb_w(memwb_w), .pc_sel(pc_sel), .pc_target(pc_target),
    .align_err(align_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        v;
    logic [9:0]  m;
    logic        z;
    logic [31:0] a;
    logic        e_wb;
    logic        e_err;
    logic        e_sel;
    logic [31:0] e_tgt;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  // One memory operation: entry cycle, waits+1 ACCESS cycles (ack in the last), DONE
  task automatic mem_op(input string nm, input logic [9:0] m, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdata, input int waits,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                        input logic [31:0] e_wdata, input logic [31:0] e_ld);
    int stalls;
    int wb_early;
    @(posedge clk); #1;
    valid = 1'b1; m_ctl = m; aluout = a; rd2 = d; dm_ack = 1'b0; dm_rdata = 32'h0;
    @(negedge clk);
    chk({nm, " entry stall"}, 32'(stall), 32'd1);
    chk({nm, " entry req"}, 32'(dm_req), 32'd0);
    stalls   = stall ? 1 : 0;
    wb_early = memwb_w ? 1 : 0;
    for (int c = 0; c <= waits; c++) begin
      @(posedge clk); #1;
      dm_ack   = (c == waits);
      dm_rdata = (c == waits) ? rdata : 32'h0;
      @(negedge clk);
      if (stall) stalls++;
      if (memwb_w) wb_early++;
      if (c == 0) begin
        chk({nm, " req"}, 32'(dm_req), 32'd1);
        chk({nm, " addr"}, dm_addr, e_addr);
        chk({nm, " be"}, 32'(dm_be), 32'(e_be));
        chk({nm, " we"}, 32'(dm_we), 32'(e_we));
        if (e_we) chk({nm, " wdata"}, dm_wdata, e_wdata);
      end
    end
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk({nm, " done wb"}, 32'(memwb_w), 32'd1);
    chk({nm, " done stall"}, 32'(stall), 32'd0);
    chk({nm, " done req"}, 32'(dm_req), 32'd0);
    chk({nm, " ld_data"}, ld_data, e_ld);
    chk({nm, " stall cycles"}, 32'(stalls), 32'(waits + 2));
    chk({nm, " early wb"}, 32'(wb_early), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; m_ctl = 10'h0;
    @(negedge clk);
    chk({nm, " wb after"}, 32'(memwb_w), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rd1 = 32'h800; jaddr = 32'h900; addres = 32'h400;
    //        v     m       z     addr       wb    err   sel   tgt
    vt[0]  = '{1'b0, 10'h001, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 10'h000, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 10'h001, 1'b0, 32'h101, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 10'h041, 1'b0, 32'h103, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 10'h0C1, 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 10'h002, 1'b0, 32'h102, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 10'h004, 1'b1, 32'h0,   1'b1, 1'b0, 1'b1, 32'h400};
    vt[7]  = '{1'b1, 10'h008, 1'b1, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 10'h008, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h400};
    vt[9]  = '{1'b1, 10'h004, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 10'h030, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h800};
    vt[11] = '{1'b1, 10'h010, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h900};
    vt[12] = '{1'b1, 10'h014, 1'b1, 32'h0,   1'b1, 1'b0, 1'b1, 32'h900};
    vt[13] = '{1'b0, 10'h020, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
    vt[14] = '{1'b1, 10'h200, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};

    rstn = 1'b0; valid = 1'b0; m_ctl = 10'h0; zero = 1'b0; aluout = 32'h0;
    rd2 = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    #12;
    chk("reset req", 32'(dm_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset wb", 32'(memwb_w), 32'd0);
    chk("reset ld_data", ld_data, 32'h0);
    chk("reset pc_sel", 32'(pc_sel), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      valid = vt[i].v; m_ctl = vt[i].m; zero = vt[i].z; aluout = vt[i].a;
      @(negedge clk);
      chk($sformatf("vec%0d wb", i), 32'(memwb_w), 32'(vt[i].e_wb));
      chk($sformatf("vec%0d err", i), 32'(align_err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d sel", i), 32'(pc_sel), 32'(vt[i].e_sel));
      chk($sformatf("vec%0d tgt", i), pc_target, vt[i].e_tgt);
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
      chk($sformatf("vec%0d req", i), 32'(dm_req), 32'd0);
      chk($sformatf("vec%0d ld", i), ld_data, 32'h0);
    end
    @(posedge clk); #1;
    valid = 1'b0; m_ctl = 10'h0; zero = 1'b0;

    mem_op("lw",  10'h001, 32'h100, 32'h0, 32'hDEADBEEF, 2, 32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
    mem_op("lbs", 10'h181, 32'h103, 32'h0, 32'h80112233, 0, 32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80);
    mem_op("lbu", 10'h081, 32'h103, 32'h0, 32'h80112233, 1, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h00000080);
    mem_op("lhs", 10'h141, 32'h102, 32'h0, 32'h8001FFFF, 0, 32'h100, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001);
    mem_op("sh",  10'h042, 32'h102, 32'h0000ABCD, 32'h0, 0, 32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0);
    mem_op("rw",  10'h003, 32'h104, 32'h12345678, 32'hFFFF0000, 0, 32'h104, 4'b1111, 1'b1, 32'h12345678, 32'h0);

    // Redirect is not raised while the access holds EX/MEM
    @(posedge clk); #1;
    valid = 1'b1; m_ctl = 10'h021; aluout = 32'h200;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("access no redirect", 32'(pc_sel), 32'd0);
    dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("done no redirect", 32'(pc_sel), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; m_ctl = 10'h0;

    // Asynchronous reset in the middle of an access
    @(posedge clk); #1;
    valid = 1'b1; m_ctl = 10'h001; aluout = 32'h100;
    @(posedge clk); #1;
    chk("pre-reset req", 32'(dm_req), 32'd1);
    rstn = 1'b0; valid = 1'b0; m_ctl = 10'h0;
    #1;
    chk("reset drops req", 32'(dm_req), 32'd0);
    chk("reset drops stall", 32'(stall), 32'd0);
    #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("post-reset req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("stray ack wb", 32'(memwb_w), 32'd0);
    chk("stray ack ld", ld_data, 32'h0);

`ifdef MEM_TIMEOUT_EN
    begin
      int acc_cycles;
      int err_seen;
      acc_cycles = 0;
      err_seen = 0;
      @(posedge clk); #1;
      valid = 1'b1; m_ctl = 10'h001; aluout = 32'h100;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (!dm_req) break;
        acc_cycles++;
        if (align_err) err_seen++;
      end
      chk("timeout access cycles", 32'(acc_cycles), 32'd4);
      chk("timeout err pulse", 32'(err_seen), 32'd1);
      chk("timeout done wb", 32'(memwb_w), 32'd1);
      chk("timeout done stall", 32'(stall), 32'd0);
      chk("timeout ld", ld_data, 32'h0);
      @(posedge clk); #1;
      valid = 1'b0; m_ctl = 10'h0;
    end
`endif

    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
